// File: rtl/alu_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// alu_cmd_arbiter
//
// Shares the single write port of the ALU command FIFO among NREQ command
// producers in the p_clk domain. Each producer raises req with a stable
// 32-bit command and holds it until it sees a one-cycle ack. The arbiter
// captures the winning command into data_out, raises w_req, and keeps the
// command there until the FIFO accepts it (an edge with full low). Accepted
// writes are counted in wr_cnt.
//
// Command layout (not decoded here, passed through bit for bit):
//   [31:29] opcode, [28:15] operand A, [14:1] operand B, [0] pad
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   DW    command width
//   IW    grant index width
//
// Ports:
//   p_clk     in   processor clock, all logic on its rising edge
//   rst       in   asynchronous active-low reset
//   req       in   per-requester command valid, held until ack
//   cmd       in   flattened commands, requester i at [i*DW +: DW]
//   ack       out  registered one-cycle pulse: requester's command captured
//   full      in   FIFO full flag
//   w_req     out  registered FIFO write request
//   data_out  out  registered command to the FIFO data_in
//   grant_id  out  index of the requester whose command is on data_out
//   busy      out  high while in the ISSUE state
//   wr_cnt    out  accepted FIFO writes, wraps 0xFFFF -> 0
//
// Build option:
//   ARB_PRIO0_EN  when defined, requester 0 wins whenever it is eligible and
//                 requesters 1..NREQ-1 share round-robin among themselves;
//                 rr_ptr then only moves on grants to 1..NREQ-1. When not
//                 defined, all NREQ requesters are served round-robin.
// -----------------------------------------------------------------------------
module alu_cmd_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic                p_clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*DW-1:0]  cmd,
   output logic [NREQ-1:0]     ack,
   input  logic                full,
   output logic                w_req,
   output logic [DW-1:0]       data_out,
   output logic [IW-1:0]       grant_id,
   output logic                busy,
   output logic [15:0]         wr_cnt
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;

   // Index of the most recent round-robin winner; the search starts just
   // above it so every requester gets a turn.
   logic [IW-1:0]   rr_ptr;

   logic [NREQ-1:0] elig;
   logic            any_elig;

   logic            hi_found;
   int              hi_idx;
   int              lo_idx;
   int              win_idx;
   logic [IW-1:0]   winner;
   logic [NREQ-1:0] win_onehot;
   logic [DW-1:0]   win_cmd;
   logic            win_moves_ptr;

   logic            do_grant;
   logic            do_count;

   // A requester acked this cycle is still showing the command we just took
   // (or is swapping in a new one), so it must sit out this edge.
   assign elig     = req & ~ack;
   assign any_elig = |elig;

   // ---------------------------------------------------------------------------
   // Winner selection.
   // Eligible indices above rr_ptr are preferred over those at or below it,
   // and within each group the lowest index wins: that is the first eligible
   // index found searching upward from rr_ptr+1 with wrap-around. Scanning
   // downward makes the last hit in each group the lowest one.
   // ---------------------------------------------------------------------------
`ifdef ARB_PRIO0_EN
   localparam int RR_LO = 1;
`else
   localparam int RR_LO = 0;
`endif

   // NOTE: every signal written in an always_comb gets a default at the top of
   // the block; a path that leaves one unassigned would infer a latch.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = 0;
      lo_idx   = 0;
      for (int i = NREQ - 1; i >= RR_LO; i--) begin
         if (elig[i]) begin
            if (i > int'(rr_ptr)) begin
               hi_found = 1'b1;
               hi_idx   = i;
            end else begin
               lo_idx   = i;
            end
         end
      end

      win_idx = hi_found ? hi_idx : lo_idx;
`ifdef ARB_PRIO0_EN
      if (elig[0]) begin
         win_idx = 0;
      end
`endif
      winner = IW'(win_idx);

      // Requester 0 does not disturb the rotation among the others when it
      // wins through priority.
`ifdef ARB_PRIO0_EN
      win_moves_ptr = (win_idx != 0);
`else
      win_moves_ptr = 1'b1;
`endif
   end

   // Mux the winning command and build the ack pattern with constant indices
   // so the selection unrolls into plain AND-OR logic.
   always_comb begin
      win_onehot = '0;
      win_cmd    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (i == win_idx) begin
            win_onehot[i] = 1'b1;
            win_cmd       = cmd[i*DW +: DW];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the values from before the edge, independent of block ordering.
   always_ff @(posedge p_clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and datapath controls
   //   IDLE : grant as soon as anything is eligible; capture ignores full.
   //   ISSUE: with full low the current write is accepted at this edge, so
   //          either the next winner is loaded (back-to-back) or we drop to
   //          IDLE. With full high everything holds.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_count  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (any_elig) begin
               do_grant  = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!full) begin
               do_count = 1'b1;
               if (any_elig) begin
                  do_grant = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge p_clk or negedge rst) begin
      if (!rst) begin
         ack      <= '0;
         data_out <= '0;
         grant_id <= '0;
         rr_ptr   <= IW'(NREQ - 1);
         wr_cnt   <= '0;
      end else begin
         // ack is high only in the cycle right after a grant; a stall edge
         // never grants, so it also clears any pending ack.
         ack <= do_grant ? win_onehot : '0;

         if (do_grant) begin
            data_out <= win_cmd;
            grant_id <= winner;
            if (win_moves_ptr) begin
               rr_ptr <= winner;
            end
         end

         if (do_count) begin
            wr_cnt <= wr_cnt + 16'd1;
         end
      end
   end

   // w_req and busy come straight off the state flop, so they stay glitch-free
   // and drop as soon as reset is asserted.
   assign w_req = (state == S_ISSUE);
   assign busy  = (state == S_ISSUE);

endmodule
